// File: rtl/gray_code_pkg.sv
// Shared constants and pure conversion functions for the Gray code block.
package gray_code_pkg;

   // Widest word the width-generic helpers handle; callers zero-extend into it.
   localparam int unsigned MAX_WIDTH = 64;

   localparam logic MODE_BIN2GRAY = 1'b0;
   localparam logic MODE_GRAY2BIN = 1'b1;

   typedef logic [MAX_WIDTH-1:0] word_t;

   // Binary to Gray: each bit XORed with its upper neighbour. Zero upper bits
   // leave the narrower result unchanged, so any width <= MAX_WIDTH works.
   function automatic word_t bin2gray(input word_t x);
      return x ^ (x >> 1);
   endfunction

   // Gray to binary: prefix XOR from the MSB down as one combinational chain.
   // Zero-extended upper bits contribute nothing to the lower prefix.
   function automatic word_t gray2bin(input word_t x);
      word_t y;
      y = x;
      for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
         y[i] = y[i+1] ^ x[i];
      end
      return y;
   endfunction

endpackage

// File: rtl/gray_conv_comb.sv
// Combinational binary<->Gray converter, direction chosen by mode.
module gray_conv_comb
   import gray_code_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] x,
   input  logic             mode,
   output logic [WIDTH-1:0] y
);

   // Reject widths the helpers cannot represent.
   if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("gray_conv_comb: WIDTH out of range");
   end

   word_t x_ext;

   assign x_ext = MAX_WIDTH'(x);

   // Select conversion direction; Gray encode is the default.
   always_comb begin
      y = WIDTH'(bin2gray(x_ext));
      if (mode == MODE_GRAY2BIN) begin
         y = WIDTH'(gray2bin(x_ext));
      end
   end

endmodule

// File: rtl/gray_code.sv
// 4-bit combinational Gray encoder plus a registered WIDTH-generic converter.
module gray_code
   import gray_code_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a,
   input  logic             b,
   input  logic             c,
   input  logic             d,
   output logic [3:0]       f,
   input  logic             in_valid,
   input  logic             mode,
   input  logic [WIDTH-1:0] din,
   output logic             out_valid,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] conv_word;

   // Scalar path: always binary->Gray, independent of clock and reset.
   gray_conv_comb #(
      .WIDTH (4)
   ) u_conv_bits (
      .x    ({a, b, c, d}),
      .mode (MODE_BIN2GRAY),
      .y    (f)
   );

   // Word path converter feeding the output register.
   gray_conv_comb #(
      .WIDTH (WIDTH)
   ) u_conv_word (
      .x    (din),
      .mode (mode),
      .y    (conv_word)
   );

   // Capture converted word on valid input; dout holds when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout      <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            dout <= conv_word;
         end
      end
   end

endmodule

// File: tb/tb_gray_code.sv
// Directed self-checking bench for gray_code.
module tb_gray_code;

   logic       clk;
   logic       rst_n;
   logic       a, b, c, d;
   logic [3:0] f;
   logic       in_valid;
   logic       mode;
   logic [3:0] din;
   logic       out_valid;
   logic [3:0] dout;
   logic       clk_en;

   int checks;
   int errors;

   gray_code #(
      .WIDTH (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a),
      .b         (b),
      .c         (c),
      .d         (d),
      .f         (f),
      .in_valid  (in_valid),
      .mode      (mode),
      .din       (din),
      .out_valid (out_valid),
      .dout      (dout)
   );

   // Clock stays idle low until enabled.
   initial begin
      clk = 1'b0;
      wait (clk_en);
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_abcd(input logic [3:0] v);
      {a, b, c, d} = v;
   endtask

   initial begin
      logic [3:0] prev_f;
      logic [3:0] xv;
      checks   = 0;
      errors   = 0;
      clk_en   = 1'b0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      mode     = 1'b0;
      din      = 4'h0;
      set_abcd(4'b0000);
      #5;

      // Reset state of the registered path.
      check("rst_dout", 8'(dout), 8'h00);
      check("rst_out_valid", 8'(out_valid), 8'h00);

      // Directed combinational cases, in reset with clock idle.
      set_abcd(4'b0001); #5; check("comb_0001", 8'(f), 8'b0001);
      set_abcd(4'b0010); #5; check("comb_0010", 8'(f), 8'b0011);
      set_abcd(4'b0111); #5; check("comb_0111", 8'(f), 8'b0100);
      set_abcd(4'b1111); #5; check("comb_1111", 8'(f), 8'b1000);

      // Exhaustive sweep with single-bit-change check, including wrap.
      prev_f = 4'b0000;
      for (int i = 0; i < 16; i++) begin
         xv = 4'(i);
         set_abcd(xv);
         #1;
         check("sweep_f", 8'(f), 8'(xv ^ (xv >> 1)));
         if (i > 0) check("sweep_1bit", 8'($countones(f ^ prev_f)), 8'd1);
         prev_f = f;
      end
      set_abcd(4'b0000);
      #1;
      check("wrap_1bit", 8'($countones(f ^ prev_f)), 8'd1);

      // Release reset, then start the clock.
      rst_n  = 1'b1;
      #2;
      clk_en = 1'b1;

      // mode=0 single word, then idle.
      @(negedge clk);
      in_valid = 1'b1; mode = 1'b0; din = 4'b0101;
      @(negedge clk);
      check("b2g_dout", 8'(dout), 8'b0111);
      check("b2g_valid", 8'(out_valid), 8'h01);
      in_valid = 1'b0;
      @(negedge clk);
      check("idle_valid", 8'(out_valid), 8'h00);
      check("idle_hold", 8'(dout), 8'b0111);

      // mode=1 back-to-back words.
      in_valid = 1'b1; mode = 1'b1; din = 4'b0111;
      @(negedge clk);
      check("g2b_0111", 8'(dout), 8'b0101);
      check("g2b_valid0", 8'(out_valid), 8'h01);
      din = 4'b1111;
      @(negedge clk);
      check("g2b_1111", 8'(dout), 8'b1010);
      check("g2b_valid1", 8'(out_valid), 8'h01);

      // Binary all-ones encodes to 1000.
      mode = 1'b0; din = 4'b1111;
      @(negedge clk);
      check("b2g_ones", 8'(dout), 8'b1000);

      // Round trip: Gray of x fed in with mode=1 returns x.
      mode = 1'b1;
      for (int i = 0; i < 16; i++) begin
         xv  = 4'(i);
         din = xv ^ (xv >> 1);
         @(negedge clk);
         check("roundtrip", 8'(dout), 8'(xv));
         check("rt_valid", 8'(out_valid), 8'h01);
      end

      // Reset mid-stream, between edges, with valid output.
      din = 4'b0111;
      @(negedge clk);
      check("pre_rst_valid", 8'(out_valid), 8'h01);
      #2;
      rst_n = 1'b0;
      set_abcd(4'b1010);
      #1;
      check("midrst_dout", 8'(dout), 8'h00);
      check("midrst_valid", 8'(out_valid), 8'h00);
      check("midrst_f", 8'(f), 8'b1111);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      set_abcd(4'b0110);
      @(negedge clk);
      @(negedge clk);
      check("post_rst_dout", 8'(dout), 8'h00);
      check("post_rst_valid", 8'(out_valid), 8'h00);
      check("post_rst_f", 8'(f), 8'b0101);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
